// File: rtl/ad9361_pkg.sv
// Shared constants and types for the AD9361 nibble-FIFO read path.
// No ports; imported by the reader top level and its skid buffer.
package ad9361_pkg;

  localparam int AD9361_SAMPLE_W           = 12;
  localparam int AD9361_NIBBLES_PER_SAMPLE = 3;
  localparam int FIFO18_RD_LATENCY_DOREG   = 2;

  // Number of nibbles already collected for the sample being assembled.
  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_ONE  = 2'd1,
    PH_TWO  = 2'd2
  } nib_phase_e;

endpackage

// File: rtl/ad9361_skid_fifo.sv
// Small synchronous FIFO that catches nibbles landing from the FIFO18E1
// read pipeline so the packer can stall without losing in-flight data.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          synchronous drop of all stored entries
//   push_i/push_data_i  write one entry
//   pop_i/pop_data_o    head entry and its removal (pop when empty is ignored)
//   empty_o, count_o    occupancy
module ad9361_skid_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Wrapping increment so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The reader's credit scheme must never push into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/ad9361_fifo_reader.sv
// Read-side controller for the AD9361 nibble FIFO (FIFO18E1, DO_REG=1).
// Issues RDEN only when data is present and landing space is reserved,
// absorbs the read latency, packs three nibbles LSB-first into a sample
// and presents it on a valid/ready stream.
// Ports:
//   clk, reset_n          read clock, asynchronous active-low reset
//   enable, clear         read permit, synchronous abort
//   fifo_empty, fifo_do   FIFO EMPTY flag and DO
//   fifo_rd_en            FIFO RDEN
//   m_data/m_valid/m_ready  output sample stream, {n2,n1,n0}
//   underrun              sticky starvation flag
//   nib_phase             nibbles held in the partial sample
module ad9361_fifo_reader
  import ad9361_pkg::*;
#(
  parameter int FIFO_DW    = AD9361_SAMPLE_W / AD9361_NIBBLES_PER_SAMPLE,
  parameter int SAMPLE_W   = AD9361_SAMPLE_W,
  parameter int RD_LATENCY = FIFO18_RD_LATENCY_DOREG,
  parameter int SKID_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  input  logic                fifo_empty,
  input  logic [FIFO_DW-1:0]  fifo_do,
  output logic                fifo_rd_en,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                underrun,
  output logic [1:0]          nib_phase
);

  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int INF_W      = $clog2(RD_LATENCY + 1);

  logic [RD_LATENCY-1:0]  tok_q, tok_d;
  logic [INF_W-1:0]       inflight;
  logic                   run_q;
  logic                   credit_ok;
  logic                   land;

  logic [FIFO_DW-1:0]     skid_do;
  logic                   skid_empty;
  logic [SKID_CNT_W-1:0]  skid_count;
  logic                   pop;
  logic                   stall;

  nib_phase_e             phase_q, phase_d;
  logic [2*FIFO_DW-1:0]   partial_q, partial_d;
  logic [SAMPLE_W-1:0]    data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   underrun_q, underrun_d;

  // Reads in flight are the set bits of the token pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + INF_W'(tok_q[i]);
    end
  end

  // Every nibble either in flight or parked in the skid buffer holds a slot,
  // so a read is only issued when its landing slot is already reserved.
  assign credit_ok  = (32'(inflight) + 32'(skid_count)) < 32'(SKID_DEPTH);
  // run_q keeps RDEN low while reset is asserted, even with enable high.
  assign fifo_rd_en = run_q && enable && !clear && !fifo_empty && credit_ok;
  assign land       = tok_q[RD_LATENCY-1];

  always_comb begin
    tok_d    = '0;
    tok_d[0] = fifo_rd_en;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tok_d[i] = tok_q[i-1];
    end
    if (clear) tok_d = '0;
  end

  ad9361_skid_fifo #(
    .WIDTH (FIFO_DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (reset_n),
    .flush_i     (clear),
    .push_i      (land && !clear),
    .push_data_i (fifo_do),
    .pop_i       (pop),
    .pop_data_o  (skid_do),
    .empty_o     (skid_empty),
    .count_o     (skid_count)
  );

  // Only the sample-completing pop needs the output register free; the first
  // two nibbles can always be taken into the partial register.
  assign stall = (phase_q == PH_TWO) && valid_q && !m_ready;
  assign pop   = !skid_empty && !stall && !clear;

  always_comb begin
    phase_d    = phase_q;
    partial_d  = partial_q;
    data_d     = data_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;

    if (valid_q && m_ready) valid_d = 1'b0;

    if (pop) begin
      case (phase_q)
        PH_NONE: begin
          partial_d[FIFO_DW-1:0] = skid_do;
          phase_d                = PH_ONE;
        end
        PH_ONE: begin
          partial_d[2*FIFO_DW-1:FIFO_DW] = skid_do;
          phase_d                        = PH_TWO;
        end
        default: begin
          data_d  = {skid_do, partial_q};
          valid_d = 1'b1;
          phase_d = PH_NONE;
        end
      endcase
    end

    if (enable && m_ready && !valid_q && fifo_empty && skid_empty && (inflight == '0)) begin
      underrun_d = 1'b1;
    end

    if (clear) begin
      phase_d    = PH_NONE;
      partial_d  = '0;
      valid_d    = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      tok_q      <= '0;
      phase_q    <= PH_NONE;
      partial_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      tok_q      <= tok_d;
      phase_q    <= phase_d;
      partial_q  <= partial_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign underrun  = underrun_q;
  assign nib_phase = phase_q;

endmodule

// File: tb/tb_ad9361_fifo_reader.sv
// Bench for ad9361_fifo_reader: a FIFO18E1 read model (2-cycle DO latency),
// a sample scoreboard drained by a monitor, and directed checks funnelled
// through the same monitor.
module tb_ad9361_fifo_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, clear, fifo_empty, fifo_rd_en;
  logic        m_valid, m_ready, underrun, force_empty;
  logic [3:0]  fifo_do, st1;
  logic [11:0] m_data, exp_s;
  logic [1:0]  nib_phase;

  logic [3:0]  mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [11:0] sb[$];
  string       cname[$];
  int          cact[$];
  int          cexp[$];
  int          total = 0;
  int          bad = 0;

  int rd_cnt, first_rd, last_rd, t3, v1, v2;
  logic prev_v;

  ad9361_fifo_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_do    (fifo_do),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .underrun   (underrun),
    .nib_phase  (nib_phase)
  );

  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  // FIFO18E1 with output register: RDEN in cycle t -> DO valid in cycle t+2.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      st1    <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
    fifo_do <= st1;
  end

  // Monitor: sample scoreboard, RDEN-while-empty guard, directed checks.
  always @(negedge clk) begin
    if (reset_n && !clear && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sample_unexpected got=%h want=none", m_data);
      end else begin
        exp_s = sb.pop_front();
        if (m_data !== exp_s) begin
          bad++;
          $display("FAIL sample got=%h want=%h", m_data, exp_s);
        end
      end
    end
    if (fifo_rd_en) begin
      total++;
      if (fifo_empty) begin
        bad++;
        $display("FAIL rd_while_empty empty=%0d want=0", fifo_empty);
      end
    end
    while (cname.size() > 0) begin
      string n;
      int a, e;
      n = cname.pop_front();
      a = cact.pop_front();
      e = cexp.pop_front();
      total++;
      if (a != e) begin
        bad++;
        $display("FAIL %s got=%0d want=%0d", n, a, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    cname.push_back(name);
    cact.push_back(act);
    cexp.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] n);
    mem[wr_ptr[7:0]] = n;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_clear();
    step();
    enable = 1'b0;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    run(2);
    @(negedge clk);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_phase", int'(nib_phase), 0);
    step();
    reset_n = 1'b1;
    run(2);

    // Nibbles 1..6 at full rate.
    for (int i = 1; i <= 6; i++) load(4'(i));
    sb.push_back(12'h321);
    sb.push_back(12'h654);
    enable = 1'b1; m_ready = 1'b1;
    rd_cnt = 0; first_rd = -1; last_rd = -1; t3 = -1; v1 = -1; v2 = -1; prev_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        if (rd_cnt == 3) t3 = i;
      end
      if (m_valid && !prev_v) begin
        if (v1 < 0) v1 = i;
        else if (v2 < 0) v2 = i;
      end
      prev_v = m_valid;
      step();
    end
    check("t1_rd_cnt", rd_cnt, 6);
    check("t1_rd_contig", last_rd - first_rd, 5);
    check("t1_latency", v1 - t3, 4);
    check("t1_gap", v2 - v1, 3);
    @(negedge clk);
    check("t1_underrun", int'(underrun), 1);
    do_clear();
    @(negedge clk);
    check("clr_underrun", int'(underrun), 0);

    // Backpressure: 24 nibbles, m_ready low for 20 cycles.
    m_ready = 1'b0;
    for (int i = 0; i < 24; i++) load(4'(i));
    sb.push_back(12'h210); sb.push_back(12'h543); sb.push_back(12'h876);
    sb.push_back(12'hBA9); sb.push_back(12'hEDC); sb.push_back(12'h10F);
    sb.push_back(12'h432); sb.push_back(12'h765);
    step();
    enable = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      step();
    end
    @(negedge clk);
    check("t2_rd_cnt", rd_cnt, 9);
    check("t2_rd_held", int'(fifo_rd_en), 0);
    check("t2_phase", int'(nib_phase), 2);
    check("t2_valid", int'(m_valid), 1);
    step();
    m_ready = 1'b1;
    run(40);
    @(negedge clk);
    check("t2_drained", sb.size(), 0);
    do_clear();

    // EMPTY toggling every two cycles.
    m_ready = 1'b1;
    load(4'h5); load(4'hA); load(4'h3);
    load(4'hC); load(4'h6); load(4'h9);
    load(4'h1); load(4'hF); load(4'h7);
    sb.push_back(12'h3A5); sb.push_back(12'h96C); sb.push_back(12'h7F1);
    step();
    enable = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      force_empty = ((i / 2) % 2) == 1;
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      step();
    end
    force_empty = 1'b0;
    run(8);
    @(negedge clk);
    check("t3_rd_cnt", rd_cnt, 9);
    do_clear();

    // Partial sample held across enable low.
    m_ready = 1'b1;
    load(4'h1); load(4'h2);
    step();
    enable = 1'b1;
    run(8);
    enable = 1'b0;
    @(negedge clk);
    check("t4_phase2", int'(nib_phase), 2);
    check("t4_no_valid", int'(m_valid), 0);
    step();
    load(4'hA);
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      step();
    end
    check("t4_no_rd_disabled", rd_cnt, 0);
    sb.push_back(12'hA21);
    enable = 1'b1;
    run(10);
    @(negedge clk);
    check("t4_phase0", int'(nib_phase), 0);
    do_clear();

    // clear with a read in flight.
    m_ready = 1'b0;
    load(4'hE);
    step();
    enable = 1'b1;
    @(negedge clk);
    check("t5_rd", int'(fifo_rd_en), 1);
    step();
    enable = 1'b0;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
    run(4);
    @(negedge clk);
    check("t5_phase", int'(nib_phase), 0);
    check("t5_valid", int'(m_valid), 0);
    step();
    load(4'h4); load(4'h8); load(4'hB);
    sb.push_back(12'hB84);
    m_ready = 1'b1;
    enable  = 1'b1;
    run(12);
    @(negedge clk);
    check("t5_phase_end", int'(nib_phase), 0);
    do_clear();

    // Reset mid-sample, then underrun from reset.
    m_ready = 1'b1;
    load(4'h3); load(4'h5);
    step();
    enable = 1'b1;
    run(8);
    @(negedge clk);
    check("t6_pre_phase", int'(nib_phase), 2);
    reset_n = 1'b0;
    #1;
    check("t6_async_phase", int'(nib_phase), 0);
    check("t6_async_underrun", int'(underrun), 0);
    step();
    step();
    reset_n = 1'b1;
    run(4);
    @(negedge clk);
    check("t6_underrun_set", int'(underrun), 1);
    step();
    load(4'h7); load(4'h0); load(4'h9);
    sb.push_back(12'h907);
    run(10);
    @(negedge clk);
    check("t6_underrun_sticky", int'(underrun), 1);
    check("t6_phase", int'(nib_phase), 0);
    do_clear();
    @(negedge clk);
    check("t6_underrun_clr", int'(underrun), 0);

    run(3);
    @(negedge clk);
    check("end_sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad9361_fifo_reader.md
# ad9361_fifo_reader

Read-side controller for the AD9361 nibble FIFO (FIFO18E1, 4-bit port, output register enabled, standard non-FWFT mode). It runs in the FIFO read-clock domain and issues read enables only when data is present and downstream space is guaranteed. It absorbs the fixed read latency, packs three 4-bit nibbles LSB-first into one 12-bit AD9361 sample, and presents samples on a valid/ready stream.

## Interface
Parameters:
- FIFO_DW, 4: FIFO read-data width.
- SAMPLE_W, 12: output sample width. Must equal 3*FIFO_DW.
- RD_LATENCY, 2: cycles from fifo_rd_en high to fifo_do valid (FIFO18E1 with DO_REG=1).
- SKID_DEPTH, 4: nibble skid buffer entries. Must be at least RD_LATENCY+2 for full throughput.

Ports:
- clk  in  1  read clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new FIFO reads.
- clear  in  1  synchronous abort; drops all buffered and in-flight data.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_do  in  FIFO_DW  FIFO DO.
- fifo_rd_en  out  1  FIFO RDEN.
- m_data  out  SAMPLE_W  packed sample, {n2,n1,n0}; n0 is the first nibble read.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- underrun  out  1  sticky starvation flag.
- nib_phase  out  2  count of nibbles held in the partial sample (0..2).

## Operation
- Read issue: fifo_rd_en = enable & !clear & !fifo_empty & (inflight + skid_count < SKID_DEPTH). The block never asserts fifo_rd_en while fifo_empty=1, so the FIFO never reports RDERR.
- In-flight tracking: a RD_LATENCY-deep shift register of valid tokens. When a token exits, the clock edge ending cycle t+RD_LATENCY writes fifo_do into the skid buffer. Credit accounting guarantees the skid buffer never overflows; an overflow is an assertion failure.
- Packer: pops the skid head whenever the skid buffer is non-empty and the packer is not stalled.
  - The packer stalls only when nib_phase=2, m_valid=1 and m_ready=0.
  - The first two nibbles go into the partial register.
  - On the third nibble, {nibble, partial} loads m_data, m_valid is set and nib_phase returns to 0.
- Output rules: m_data and m_valid hold stable while m_valid & !m_ready. A transfer occurs on m_valid & m_ready. A load and a transfer may happen in the same cycle, so back-to-back samples need no bubble.
- enable low: no new reads are issued. In-flight nibbles still land, the packer continues, and partial samples are kept until enable returns.
- clear: at the next edge the following all reset, and fifo_rd_en stays low during the clear cycle:
  - the token pipeline (in-flight data is discarded);
  - the skid buffer, the partial register and nib_phase;
  - m_valid, and underrun.
- underrun: set when all of the following hold at once, and stays set until clear or reset:
  - enable=1, m_ready=1, m_valid=0;
  - fifo_empty=1, the skid buffer is empty and no reads are in flight.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, underrun=0, nib_phase=0; the skid buffer is empty and no tokens are in flight.
- Read latency: rd_en in cycle t → nibble in the skid buffer from cycle t+RD_LATENCY+1 → popped in that cycle.
- Sample latency: the third nibble's rd_en in cycle t → m_valid high in cycle t+RD_LATENCY+2 (t+4 by default), with no backpressure.
- Throughput: one nibble per clock sustained, i.e. one sample every 3 clocks.
- Backpressure: with m_ready held low, fifo_rd_en drops once inflight+skid_count reaches SKID_DEPTH. No nibble is lost or reordered.
- fifo_empty rising with reads in flight: those reads complete normally.
- Simultaneous clear and m_ready: clear wins, and no transfer is counted.
- reset_n asserted mid-sample: all state returns to reset values immediately, and any partial sample is lost.

## Structure
- Shared package ad9361_pkg holds:
  - AD9361_SAMPLE_W=12;
  - AD9361_NIBBLES_PER_SAMPLE=3;
  - FIFO18_RD_LATENCY_DOREG=2.
  Parameter defaults reference these constants.
- One sub-module, ad9361_skid_fifo: a synchronous FIFO with parameterised width and depth, push/pop ports and a count output, asynchronous active-low reset. The token pipeline, credit logic, packer and underrun logic stay in the top level.

## Test plan
- FIFO preloaded with nibbles 1,2,3,4,5,6; enable=1; m_ready=1 → fifo_rd_en high for 6 consecutive cycles. m_data=0x321 is valid at cycle t+4 after the 3rd read, then 0x654 three cycles later.
- Preload 24 nibbles; hold m_ready=0 for 20 cycles → fifo_rd_en stops after SKID_DEPTH reads plus packer holdings. After m_ready rises, 8 samples come out in order and no skid overflow assertion fires.
- fifo_empty toggles every 2 cycles → fifo_rd_en is never high while fifo_empty=1, and the sample order is intact.
- Two nibbles read, then enable=0 → nib_phase=2 and m_valid stays 0. Re-enable with nibble 0xA → m_data=0xA21.
- clear pulsed one cycle after rd_en (token in flight) → the in-flight nibble is discarded, nib_phase=0 and m_valid=0. The next three nibbles form a clean sample.
- enable=1, m_ready=1, FIFO empty from reset → underrun rises and stays set after data arrives. clear returns it to 0.
